// File: rtl/pll_mon_pkg.sv
// Shared definitions for the PLL frequency monitor.
//   - default parameter values for the monitor
//   - FSM state type
//   - Gray <-> binary conversion helpers (operate on a fixed 32-bit container;
//     callers zero-extend their value in and truncate the result back)
package pll_mon_pkg;

    localparam int unsigned WIN_LOG2_DEF     = 8;
    localparam int unsigned CNT_W_DEF        = WIN_LOG2_DEF + 6;
    localparam int unsigned TOL_DEF          = 16;
    localparam int unsigned LOCK_WINDOWS_DEF = 4;
    localparam int unsigned DIV_W            = 5;
    localparam int unsigned GRAY_MAX_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2
    } mon_state_e;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < int'(GRAY_MAX_W); i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/pll_gray_sync_counter.sv
// PLL-domain edge counter with Gray-coded crossing into the osc domain.
// Ports:
//   clk_pll  in   PLL output clock being counted
//   osc      in   reference clock (destination domain)
//   resetb   in   async active-low reset; released into clk_pll via 2-flop sync
//   pll_now  out  binary PLL edge count as seen in the osc domain (decoded from
//                 the synchronised Gray register)
module pll_gray_sync_counter
    import pll_mon_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk_pll,
    input  logic             osc,
    input  logic             resetb,
    output logic [CNT_W-1:0] pll_now
);

    logic [1:0]       rst_sync_q, rst_sync_d;
    logic             pll_rstb;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gray_q, gray_d;
    logic [CNT_W-1:0] sync1_q, sync1_d;
    logic [CNT_W-1:0] sync2_q, sync2_d;

    // Reset asserts immediately, releases on the second clk_pll edge.
    always_comb begin
        rst_sync_d = {rst_sync_q[0], 1'b1};
    end

    always_ff @(posedge clk_pll or negedge resetb) begin
        if (!resetb) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

    assign pll_rstb = rst_sync_q[1];

    // Free-running counter; only the Gray register is sampled by osc, so at
    // most one bit is in flight at any osc edge.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        gray_d = CNT_W'(bin2gray(GRAY_MAX_W'(cnt_q)));
    end

    always_ff @(posedge clk_pll or negedge pll_rstb) begin
        if (!pll_rstb) begin
            cnt_q  <= '0;
            gray_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
        end
    end

    // Two-flop synchroniser into osc.
    always_comb begin
        sync1_d = gray_q;
        sync2_d = sync1_q;
    end

    always_ff @(posedge osc or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pll_now = CNT_W'(gray2bin(GRAY_MAX_W'(sync2_q)));

endmodule

// File: rtl/pll_freq_monitor.sv
// PLL frequency monitor: counts clk_pll edges over 2^WIN_LOG2 osc cycles and
// qualifies the count against div * 2^WIN_LOG2.
// Ports (all outputs registered, osc domain):
//   osc         in   reference clock
//   resetb      in   async active-low reset
//   clk_pll     in   PLL output clock under observation
//   enable      in   monitor enable
//   div [4:0]   in   programmed divider (quasi-static)
//   clr_loss    in   one-cycle pulse clearing lock_lost
//   meas_count  out  edge count of the last completed window
//   meas_valid  out  one-cycle pulse when meas_count updates
//   locked      out  LOCK_WINDOWS consecutive in-tolerance windows seen
//   lock_lost   out  sticky, set when locked falls while enabled
//   pll_dead    out  last window saw no PLL edges
module pll_freq_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned WIN_LOG2     = WIN_LOG2_DEF,
    parameter int unsigned CNT_W        = WIN_LOG2 + 6,
    parameter int unsigned TOL          = TOL_DEF,
    parameter int unsigned LOCK_WINDOWS = LOCK_WINDOWS_DEF
) (
    input  logic             osc,
    input  logic             resetb,
    input  logic             clk_pll,
    input  logic             enable,
    input  logic [4:0]       div,
    input  logic             clr_loss,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             locked,
    output logic             lock_lost,
    output logic             pll_dead
);

    localparam int unsigned GOOD_W = $clog2(LOCK_WINDOWS + 1);
    localparam int unsigned DIFF_W = CNT_W + 1;

    mon_state_e        state_q, state_d;
    logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  prev_q, prev_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [CNT_W-1:0]  meas_count_q, meas_count_d;
    logic              meas_valid_q, meas_valid_d;
    logic              locked_q, locked_d;
    logic              lock_lost_q, lock_lost_d;
    logic              pll_dead_q, pll_dead_d;

    logic [CNT_W-1:0]  pll_now;
    logic              win_end;
    logic              div_change;
    logic [CNT_W-1:0]  delta;
    logic [CNT_W-1:0]  expected_cnt;
    logic [DIFF_W-1:0] diff;
    logic [DIFF_W-1:0] diff_mag;
    logic              good_win;

    pll_gray_sync_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_pll (clk_pll),
        .osc     (osc),
        .resetb  (resetb),
        .pll_now (pll_now)
    );

    // Window qualification; the subtraction is one bit wider than the count
    // so its MSB is the sign of (delta - expected).
    always_comb begin
        win_end      = (win_cnt_q == {WIN_LOG2{1'b1}});
        div_change   = (div != div_q);
        delta        = pll_now - prev_q;
        expected_cnt = CNT_W'(div_q) << WIN_LOG2;
        diff         = {1'b0, delta} - {1'b0, expected_cnt};
        diff_mag     = diff[DIFF_W-1] ? (~diff + DIFF_W'(1)) : diff;
        good_win     = (diff_mag <= DIFF_W'(TOL)) && (div_q >= DIV_W'(2));
    end

    // State register.
    always_ff @(posedge osc or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!enable)        state_d = ST_IDLE;
                else if (div_change) state_d = ST_SETTLE;
                else if (win_end)   state_d = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (!enable)        state_d = ST_IDLE;
                else if (div_change) state_d = ST_SETTLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Window counter, snapshot, result and status flag updates.
    always_comb begin
        logic lost_set;
        lost_set     = 1'b0;
        win_cnt_d    = win_cnt_q;
        prev_d       = prev_q;
        div_d        = div_q;
        good_cnt_d   = good_cnt_q;
        meas_count_d = meas_count_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        pll_dead_d   = pll_dead_q;

        if (state_q == ST_IDLE) begin
            win_cnt_d  = '0;
            div_d      = div;
            good_cnt_d = '0;
            locked_d   = 1'b0;
            pll_dead_d = 1'b0;
        end else if (!enable) begin
            win_cnt_d  = '0;
            good_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (div_change) begin
            // Restart the settle window against the new divider.
            div_d      = div;
            win_cnt_d  = '0;
            good_cnt_d = '0;
            locked_d   = 1'b0;
            lost_set   = locked_q;
        end else begin
            win_cnt_d = win_cnt_q + WIN_LOG2'(1);
            if (win_end) begin
                prev_d = pll_now;
                if (state_q == ST_MEASURE) begin
                    meas_count_d = delta;
                    meas_valid_d = 1'b1;
                    pll_dead_d   = (delta == '0);
                    if (good_win) begin
                        if (good_cnt_q != GOOD_W'(LOCK_WINDOWS)) begin
                            good_cnt_d = good_cnt_q + GOOD_W'(1);
                        end
                        if (good_cnt_d == GOOD_W'(LOCK_WINDOWS)) begin
                            locked_d = 1'b1;
                        end
                    end else begin
                        good_cnt_d = '0;
                        locked_d   = 1'b0;
                        lost_set   = locked_q;
                    end
                end
            end
        end

        // A set event in the same cycle overrides the clear request.
        if (lost_set) begin
            lock_lost_d = 1'b1;
        end else if (clr_loss) begin
            lock_lost_d = 1'b0;
        end else begin
            lock_lost_d = lock_lost_q;
        end
    end

    always_ff @(posedge osc or negedge resetb) begin
        if (!resetb) begin
            win_cnt_q    <= '0;
            prev_q       <= '0;
            div_q        <= '0;
            good_cnt_q   <= '0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
            pll_dead_q   <= 1'b0;
        end else begin
            win_cnt_q    <= win_cnt_d;
            prev_q       <= prev_d;
            div_q        <= div_d;
            good_cnt_q   <= good_cnt_d;
            meas_count_q <= meas_count_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            lock_lost_q  <= lock_lost_d;
            pll_dead_q   <= pll_dead_d;
        end
    end

    assign meas_count = meas_count_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign lock_lost  = lock_lost_q;
    assign pll_dead   = pll_dead_q;

endmodule

// File: tb/tb_pll_freq_monitor.sv
// Directed bench for pll_freq_monitor. The PLL clock is produced as a burst of
// short pulses inside each osc period, so the number of PLL edges per osc
// cycle is exact. Extra/missing pulses are placed mid-window (phase 64..) so a
// rate change made right after a result pulse applies to the whole next window.
module tb_pll_freq_monitor;

    localparam int unsigned CNT_W   = 14;
    localparam int unsigned CNT_W_S = 12;

    logic               osc = 1'b0;
    logic               clk_pll = 1'b0;
    logic               resetb;
    logic               enable;
    logic [4:0]         div;
    logic               clr_loss;
    logic [CNT_W-1:0]   meas_count;
    logic               meas_valid, locked, lock_lost, pll_dead;
    logic [CNT_W_S-1:0] meas_count_s;
    logic               meas_valid_s, locked_s, lock_lost_s, pll_dead_s;

    int checks = 0;
    int errors = 0;
    int pll_base = 8;
    int pll_extra = 0;

    pll_freq_monitor dut (
        .osc        (osc),
        .resetb     (resetb),
        .clk_pll    (clk_pll),
        .enable     (enable),
        .div        (div),
        .clr_loss   (clr_loss),
        .meas_count (meas_count),
        .meas_valid (meas_valid),
        .locked     (locked),
        .lock_lost  (lock_lost),
        .pll_dead   (pll_dead)
    );

    pll_freq_monitor #(.CNT_W(CNT_W_S)) dut_w (
        .osc        (osc),
        .resetb     (resetb),
        .clk_pll    (clk_pll),
        .enable     (enable),
        .div        (div),
        .clr_loss   (clr_loss),
        .meas_count (meas_count_s),
        .meas_valid (meas_valid_s),
        .locked     (locked_s),
        .lock_lost  (lock_lost_s),
        .pll_dead   (pll_dead_s)
    );

    always #40 osc = ~osc;

    // PLL pulse generator: pll_base pulses per osc cycle, +/-1 in |pll_extra|
    // cycles per 256-cycle period, phase re-aligned on each result pulse.
    initial begin
        int n;
        int phase;
        int ph;
        phase = 0;
        forever begin
            @(posedge osc);
            #2;
            if (meas_valid) phase = 0;
            else            phase = phase + 1;
            ph = phase % 256;
            n = pll_base;
            if (pll_extra > 0 && ph >= 64 && ph < 64 + pll_extra) n = n + 1;
            if (pll_extra < 0 && ph >= 64 && ph < 64 - pll_extra) n = n - 1;
            repeat (n) begin
                clk_pll = 1'b1;
                #2;
                clk_pll = 1'b0;
                #2;
            end
        end
    end

    initial begin
        #(80 * 100000);
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge osc);
        #1;
    endtask

    // Advance until meas_valid is seen; returns the number of osc edges taken.
    task automatic wait_pulse(input int limit, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!meas_valid && cycles < limit);
        if (!meas_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_pulse: no meas_valid within %0d cycles", limit);
        end
    endtask

    typedef struct {
        int base;
        int extra;
        int dv;
        int clr;
        int cnt;
        int lk;
        int lost;
    } vec_t;

    vec_t vecs[19];

    initial begin
        int cyc;
        vecs[0]  = '{8,   0, 8, 0, 2048, 0, 0};
        vecs[1]  = '{8,   0, 8, 0, 2048, 0, 0};
        vecs[2]  = '{8,   0, 8, 0, 2048, 1, 0};
        vecs[3]  = '{8,  16, 8, 0, 2064, 1, 0};
        vecs[4]  = '{8,  18, 8, 0, 2066, 0, 1};
        vecs[5]  = '{8,   0, 8, 0, 2048, 0, 1};
        vecs[6]  = '{8,  17, 8, 0, 2065, 0, 1};
        vecs[7]  = '{8,   0, 8, 0, 2048, 0, 1};
        vecs[8]  = '{8,   0, 8, 0, 2048, 0, 1};
        vecs[9]  = '{8,   0, 8, 0, 2048, 0, 1};
        vecs[10] = '{8,   0, 8, 0, 2048, 1, 1};
        vecs[11] = '{8,   0, 8, 1, 2048, 1, 0};
        vecs[12] = '{8, -16, 8, 0, 2032, 1, 0};
        vecs[13] = '{8, -17, 8, 0, 2031, 0, 1};
        vecs[14] = '{8,   0, 8, 0, 2048, 0, 1};
        vecs[15] = '{8,   0, 8, 0, 2048, 0, 1};
        vecs[16] = '{8,   0, 8, 0, 2048, 0, 1};
        vecs[17] = '{8,   0, 8, 0, 2048, 1, 1};
        vecs[18] = '{8,   0, 8, 1, 2048, 1, 0};

        resetb   = 1'b0;
        enable   = 1'b0;
        div      = 5'd8;
        clr_loss = 1'b0;
        repeat (3) tick();
        chk("rst_meas_count", 32'(meas_count), 0);
        chk("rst_meas_valid", 32'(meas_valid), 0);
        chk("rst_locked",     32'(locked), 0);
        chk("rst_lock_lost",  32'(lock_lost), 0);
        chk("rst_pll_dead",   32'(pll_dead), 0);

        resetb = 1'b1;
        repeat (4) tick();
        enable = 1'b1;
        wait_pulse(700, cyc);
        chk("first_pulse_latency", 32'(cyc), 513);
        chk("first_count", 32'(meas_count), 2048);
        chk("first_locked", 32'(locked), 0);

        // Window-by-window table: inputs applied right after each result.
        for (int i = 0; i < 19; i++) begin
            pll_base  = vecs[i].base;
            pll_extra = vecs[i].extra;
            div       = 5'(vecs[i].dv);
            if (vecs[i].clr != 0) begin
                clr_loss = 1'b1;
                tick();
                clr_loss = 1'b0;
            end
            wait_pulse(300, cyc);
            chk($sformatf("vec%0d_count", i),     32'(meas_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_locked", i),    32'(locked),     32'(vecs[i].lk));
            chk($sformatf("vec%0d_lock_lost", i), 32'(lock_lost),  32'(vecs[i].lost));
            chk($sformatf("vec%0d_pll_dead", i),  32'(pll_dead),   0);
        end

        // Dead clock while locked: partial window first, then an empty one.
        pll_base  = 0;
        pll_extra = 0;
        wait_pulse(300, cyc);
        chk("dead_partial_nonzero", 32'(meas_count != '0), 1);
        chk("dead_partial_locked", 32'(locked), 0);
        chk("dead_partial_lost", 32'(lock_lost), 1);
        wait_pulse(300, cyc);
        chk("dead_count", 32'(meas_count), 0);
        chk("dead_flag", 32'(pll_dead), 1);
        chk("dead_locked", 32'(locked), 0);
        chk("dead_lost", 32'(lock_lost), 1);
        clr_loss = 1'b1;
        tick();
        clr_loss = 1'b0;
        chk("dead_clr_loss", 32'(lock_lost), 0);

        // Relock, then change div while locked with a simultaneous clr_loss.
        pll_base = 8;
        for (int k = 0; k < 8 && !locked; k++) wait_pulse(300, cyc);
        chk("relock_after_dead", 32'(locked), 1);
        chk("relock_dead_clear", 32'(pll_dead), 0);
        div      = 5'd16;
        pll_base = 16;
        clr_loss = 1'b1;
        tick();
        clr_loss = 1'b0;
        chk("divchg_locked", 32'(locked), 0);
        chk("divchg_lost_set_wins", 32'(lock_lost), 1);
        wait_pulse(700, cyc);
        chk("divchg_settle_gap", 32'(cyc), 512);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) wait_pulse(300, cyc);
            chk($sformatf("div16_w%0d_count", k), 32'(meas_count), 4096);
            chk($sformatf("div16_w%0d_locked", k), 32'(locked), (k == 4) ? 1 : 0);
        end

        // Counter wrap on the 12-bit instance: 3840 edges per window.
        div      = 5'd15;
        pll_base = 15;
        for (int k = 1; k <= 4; k++) begin
            wait_pulse(700, cyc);
            chk($sformatf("wrap_w%0d_count_s", k), 32'(meas_count_s), 3840);
            chk($sformatf("wrap_w%0d_count", k), 32'(meas_count), 3840);
        end
        chk("wrap_locked_s", 32'(locked_s), 1);
        chk("wrap_locked", 32'(locked), 1);

        // Disable while locked must not set lock_lost.
        clr_loss = 1'b1;
        tick();
        clr_loss = 1'b0;
        chk("pre_disable_lost", 32'(lock_lost), 0);
        enable = 1'b0;
        tick();
        chk("disable_locked", 32'(locked), 0);
        chk("disable_lost", 32'(lock_lost), 0);
        tick();
        chk("disable_no_valid", 32'(meas_valid), 0);

        // Re-enable, lock, then reset 100 cycles into a window.
        enable = 1'b1;
        wait_pulse(700, cyc);
        chk("reenable_latency", 32'(cyc), 513);
        chk("reenable_count", 32'(meas_count), 3840);
        for (int k = 0; k < 3; k++) wait_pulse(300, cyc);
        chk("prereset_locked", 32'(locked), 1);
        repeat (99) tick();
        resetb = 1'b0;
        #1;
        chk("midrst_meas_count", 32'(meas_count), 0);
        chk("midrst_meas_valid", 32'(meas_valid), 0);
        chk("midrst_locked", 32'(locked), 0);
        chk("midrst_lock_lost", 32'(lock_lost), 0);
        chk("midrst_pll_dead", 32'(pll_dead), 0);
        chk("midrst_count_s", 32'(meas_count_s), 0);
        chk("midrst_flags_s", 32'({meas_valid_s, locked_s, lock_lost_s, pll_dead_s}), 0);
        repeat (3) tick();
        resetb = 1'b1;
        wait_pulse(700, cyc);
        chk("postrst_latency", 32'(cyc), 513);
        chk("postrst_count", 32'(meas_count), 3840);
        chk("postrst_locked", 32'(locked), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
